mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4-input, 32-bit datapath mux (and the resource behind it) among
//  four requesters. Grants one requester at a time and drives the 2-bit mux select from the grant.
//  Holds the grant until the shared resource signals completion, the requester withdraws, or a timeout fires.
//  Sits between the multicycle control unit / memory requesters and the shared-bus select mux.
// PARAMETERS
//  TIMEOUT  16  max cycles a grant may be held without iDone; 0 disables the timeout
//  CW       5   timeout counter width; must satisfy 2**CW > TIMEOUT
// PORTS
//  iCLK      in   1  clock, all state updates on rising edge
//  iRST      in   1  asynchronous, active-high reset
//  iReq      in   4  request per requester; bit n = requester n; level, held until granted and served
//  iDone     in   1  one-cycle completion pulse from the shared resource for the current grant
//  oGrant    out  4  registered one-hot grant; all-zero when idle
//  oSelect   out  2  registered mux select = index of granted requester; keeps last value when idle
//  oBusy     out  1  registered; 1 while any grant is active (state BUSY)
//  oTimeout  out  1  registered one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, oGrant=0000, oSelect=00, oBusy=0, oTimeout=0, counter=0,
//   last-served pointer=3, so requester 0 has highest priority after reset.
//  Priority: search order starts at (last+1) mod 4 and wraps, e.g. last=1 -> order 2,3,0,1.
//  States: IDLE, BUSY.
//  IDLE: if iReq!=0 at edge N, winner w is granted from edge N onward: oGrant=1<<w, oSelect=w,
//   oBusy=1, counter=0, state=BUSY. One cycle of latency from request to grant. If iReq=0, stay IDLE.
//  BUSY: the counter increments each cycle, saturating at 2**CW-1. A release occurs at the edge where any
//   of the following holds:
//   (a) iDone=1;
//   (b) iReq[w]=0 (requester withdraws / abort);
//   (c) TIMEOUT!=0 and counter==TIMEOUT-1, i.e. the grant is held exactly TIMEOUT cycles.
//  On release: last=w. With the same edge, re-arbitrate on the current iReq using the NEW pointer.
//   - If any request exists, grant the new winner immediately (back-to-back, no idle gap);
//     oBusy stays 1 and counter=0.
//   - Otherwise oGrant=0000, oBusy=0, state=IDLE.
//   A releasing requester that still holds iReq is lowest priority, so it wins only if it is alone.
//  oTimeout=1 for exactly the one cycle following a release caused solely by (c). If (a) or (b) coincides
//   with (c), the release counts as normal and oTimeout stays 0.
//  Simultaneous iDone and iReq[w] drop: a single release, with no extra pointer advance.
//  iDone while IDLE is ignored. Changes to iReq bits other than w during BUSY do not affect the grant.
//  oGrant is always one-hot or zero. oSelect changes only when a new grant is issued.
//  Reset asserted mid-grant: the grant is dropped asynchronously and the pointer returns to 3.
//   No oTimeout pulse is produced.
//  No combinational path from inputs to outputs; all outputs are flops.
// TESTING
//  1. Reset, then iReq=0001 at edge 1 -> oGrant=0001, oSelect=00, oBusy=1 after edge 1.
//     iDone at edge 4 -> oGrant=0000, oBusy=0.
//  2. iReq=1111 held, iDone pulsed every 3rd cycle -> grants in order 0,1,2,3,0 with no idle cycles
//     between them; oSelect follows the grant order.
//  3. After grant to 2 with iReq=0101: iDone -> next grant is 0 (order 3,0,1,2), then 2.
//     The lone requester 2 is re-granted after its own release when iReq=0100.
//  4. TIMEOUT=16: grant requester 1, no iDone -> release after exactly 16 granted cycles,
//     oTimeout high for 1 cycle; iDone on that same cycle -> no oTimeout.
//  5. Granted requester 3 drops iReq while granted -> released next edge, oBusy=0 if no other request.
//     iDone in IDLE -> no effect.
//  6. Assert iRST mid-grant (oGrant=0100) -> outputs clear immediately.
//     After release with iReq=1111 -> requester 0 granted first.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Bundle between the four requesters / shared resource and the round-robin arbiter.
// The requesters hold iReq[n] high until served, and iDone pulses once when the resource is finished.
interface mux_rr_arbiter_if;
  // Handshake: iReq[n] is a level request that acts as "valid" and stays high until requester n is served.
  // oGrant[n] acts as "ready": the cycle it rises, requester n owns the mux.
  // Ownership ends at the edge that sees iDone=1, iReq[n]=0, or the hold timeout.
  logic [3:0] iReq;
  logic       iDone;
  logic [3:0] oGrant;
  logic [1:0] oSelect;
  logic       oBusy;
  logic       oTimeout;
  logic       dbg_state;

  modport master (
    output iReq, iDone,
    input  oGrant, oSelect, oBusy, oTimeout, dbg_state
  );

  modport slave (
    input  iReq, iDone,
    output oGrant, oSelect, oBusy, oTimeout, dbg_state
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the 2-bit select of the shared 4:1 datapath mux.
// A grant is held until iDone arrives, the owner withdraws, or TIMEOUT cycles elapse.
module mux_rr_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input logic            iCLK,
  input logic            iRST,
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state;
  logic [3:0]    grant;
  logic [1:0]    sel;
  logic [1:0]    last;
  logic          busy;
  logic          tout;
  logic [CW-1:0] cnt;

  logic [1:0]    base;
  logic          found;
  logic [1:0]    win;
  logic          rel_done;
  logic          rel_wd;
  logic          rel_to;
  logic          release_now;

  // While busy the owner is the pointer for the re-arbitration that happens on its release edge.
  // The loop walks from lowest to highest priority so the final hit is the winner.
  always_comb begin
    base  = (state == BUSY) ? sel : last;
    found = 1'b0;
    win   = base;
    for (int i = 4; i >= 1; i--) begin
      if (bus.iReq[base + 2'(i)]) begin
        found = 1'b1;
        win   = base + 2'(i);
      end
    end
  end

  always_comb begin
    rel_done    = bus.iDone;
    rel_wd      = !bus.iReq[sel];
    rel_to      = (TIMEOUT != 0) && (cnt == CNT_LAST);
    release_now = (state == BUSY) && (rel_done || rel_wd || rel_to);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      grant <= 4'b0000;
      sel   <= 2'd0;
      last  <= 2'd3;
      busy  <= 1'b0;
      tout  <= 1'b0;
      cnt   <= '0;
    end else begin
      tout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant <= 4'b0001 << win;
            sel   <= win;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            last <= sel;
            // Timeout is only flagged when nothing else would have ended the grant anyway.
            tout <= rel_to && !rel_done && !rel_wd;
            if (found) begin
              grant <= 4'b0001 << win;
              sel   <= win;
              cnt   <= '0;
            end else begin
              grant <= 4'b0000;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oGrant    = grant;
  assign bus.oSelect   = sel;
  assign bus.oBusy     = busy;
  assign bus.oTimeout  = tout;
  assign bus.dbg_state = state;

  a_grant_onehot: assert property (@(posedge iCLK) disable iff (iRST) $onehot0(grant));
  a_busy_matches: assert property (@(posedge iCLK) disable iff (iRST) busy == (grant != 4'b0000));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic against a queue-based
// reference model; a monitor pops one expected output word per clock edge and compares.
module tb_mux_rr_arbiter;

  localparam int TIMEOUT = 16;
  localparam int CW      = 5;

  logic clk = 1'b0;
  logic rst;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected word after each edge: {grant[3:0], select[1:0], busy, timeout}
  logic [7:0] exp_q[$];

  // Reference model: who owns the mux, how many cycles it has held it, who was served last.
  int m_owner;
  int m_held;
  int m_last;
  int m_sel;
  bit m_tout;

  function automatic int pick(input logic [3:0] req, input int served);
    for (int k = 1; k <= 4; k++) begin
      if (req[(served + k) % 4]) return (served + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_word();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    return {g, 2'(m_sel), (m_owner >= 0), m_tout};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_sel   = 0;
    m_tout  = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] req, input logic done);
    int  w;
    bit  hit_to;
    bit  ends;
    m_tout = 1'b0;
    if (m_owner < 0) begin
      w = pick(req, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_held  = 1;
      end
    end else begin
      hit_to = (TIMEOUT != 0) && (m_held == TIMEOUT);
      ends   = done || !req[m_owner] || hit_to;
      if (ends) begin
        m_tout = hit_to && !done && req[m_owner];
        m_last = m_owner;
        w = pick(req, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_sel   = w;
          m_held  = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got grant=%b sel=%0d busy=%b tout=%b, expected grant=%b sel=%0d busy=%b tout=%b",
               name, $time, got[7:4], got[3:2], got[1], got[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [7:0] dut_word();
    return {bus.oGrant, bus.oSelect, bus.oBusy, bus.oTimeout};
  endfunction

  // Monitor: one expected word per clock edge, sampled 1 time unit after the edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check8("cycle", dut_word(), e);
      end
    end
  end

  // Driver: called at a falling edge; applies inputs, predicts, waits one full cycle.
  task automatic step(input logic [3:0] req, input logic done);
    bus.iReq  = req;
    bus.iDone = done;
    if (rst) begin
      model_reset();
    end else begin
      model_edge(req, done);
    end
    exp_q.push_back(model_word());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    check8("async_reset", dut_word(), 8'h00);
    model_reset();
    step(4'b1111, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rq;
    int         done_odds;
    rst       = 1'b1;
    bus.iReq  = 4'b0000;
    bus.iDone = 1'b0;
    model_reset();
    #1;
    check8("reset_state", dut_word(), 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single requester, served by iDone while it withdraws.
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // All requesting, iDone every third cycle: back-to-back rotation.
    for (int i = 0; i < 15; i++) step(4'b1111, (i % 3) == 2);

    // Two requesters sharing, then a lone requester re-granted after its own release.
    for (int i = 0; i < 9; i++) step(4'b0101, (i % 3) == 2);
    for (int i = 0; i < 6; i++) step(4'b0100, (i % 3) == 2);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Timeout on requester 1, then iDone coinciding with the timeout edge.
    for (int i = 0; i < 17; i++) step(4'b0010, 1'b0);
    for (int i = 0; i < 15; i++) step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b0);

    // Withdrawal by requester 3, then iDone while idle.
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Reset while requester 2 holds the grant; requester 0 wins afterwards.
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0);
    mid_reset();
    for (int i = 0; i < 4; i++) step(4'b1111, i == 2);
    step(4'b0000, 1'b0);

    // Randomized traffic in phases of slowly changing requests and varying iDone density.
    rq = 4'b0000;
    done_odds = 8;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) done_odds = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(2, 12);
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      step(rq, (done_odds != 0) && ($urandom_range(1, done_odds) == 1));
      if ($urandom_range(0, 499) == 0) mid_reset();
    end
    step(4'b0000, 1'b0);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
